// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: memory-latency freeze, load-use stall and halt drain for the 8-bit core.
// freeze/ld_inst_halt are Mealy outputs; fetch_stop, halted and stall_cnt come from flops.
module pipe_ctrl #(
  parameter int MEM_LAT      = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        ex_is_load,
  input  logic [5:0]  ex_write_addr,
  input  logic [5:0]  id_rs1,
  input  logic [5:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        halt_decoded,
  output logic        freeze,
  output logic        ld_inst_halt,
  output logic        fetch_stop,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  // A single-cycle memory never stretches, so the latency preload is only meaningful above 1.
  localparam logic       MEM_STRETCH = (MEM_LAT > 1);
  localparam logic [3:0] LAT_INIT    = MEM_STRETCH ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [3:0] DRAIN_INIT  = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  lat_cnt_reg, lat_cnt_next;
  logic [3:0]  drain_cnt_reg, drain_cnt_next;
  logic        ret_drain_reg, ret_drain_next;
  logic        fetch_stop_reg, halted_reg;
  logic [15:0] stall_cnt_reg;
  logic        freeze_next, ld_inst_halt_next;
  logic        luh;

  assign luh = ex_is_load && (ex_write_addr != 6'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_write_addr)) ||
                (id_uses_rs2 && (id_rs2 == ex_write_addr)));

  always_comb begin
    state_next        = state_reg;
    lat_cnt_next      = lat_cnt_reg;
    drain_cnt_next    = drain_cnt_reg;
    ret_drain_next    = ret_drain_reg;
    freeze_next       = 1'b0;
    ld_inst_halt_next = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (mem_req && MEM_STRETCH) begin
          freeze_next    = 1'b1;
          lat_cnt_next   = LAT_INIT;
          ret_drain_next = 1'b0;
          state_next     = S_MEM_WAIT;
        end else if (luh) begin
          ld_inst_halt_next = 1'b1;
        end else if (halt_decoded) begin
          drain_cnt_next = DRAIN_INIT;
          state_next     = S_DRAIN;
        end
      end
      S_MEM_WAIT: begin
        // Release cycle: mem_req still belongs to the completing access and is ignored.
        if (lat_cnt_reg != 4'd0) begin
          freeze_next  = 1'b1;
          lat_cnt_next = lat_cnt_reg - 4'd1;
        end else if (ret_drain_reg) begin
          if (drain_cnt_reg == 4'd1) begin
            state_next = S_HALTED;
          end else begin
            drain_cnt_next = drain_cnt_reg - 4'd1;
            state_next     = S_DRAIN;
          end
        end else if (luh) begin
          ld_inst_halt_next = 1'b1;
          state_next        = S_RUN;
        end else if (halt_decoded) begin
          drain_cnt_next = DRAIN_INIT;
          state_next     = S_DRAIN;
        end else begin
          state_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (mem_req && MEM_STRETCH) begin
          freeze_next    = 1'b1;
          lat_cnt_next   = LAT_INIT;
          ret_drain_next = 1'b1;
          state_next     = S_MEM_WAIT;
        end else if (drain_cnt_reg == 4'd1) begin
          state_next = S_HALTED;
        end else begin
          drain_cnt_next = drain_cnt_reg - 4'd1;
        end
      end
      S_HALTED: begin
        freeze_next = 1'b1;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
    if (rst) begin
      freeze_next       = 1'b0;
      ld_inst_halt_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_RUN;
      lat_cnt_reg    <= 4'd0;
      drain_cnt_reg  <= 4'd0;
      ret_drain_reg  <= 1'b0;
      fetch_stop_reg <= 1'b0;
      halted_reg     <= 1'b0;
      stall_cnt_reg  <= 16'd0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      drain_cnt_reg  <= drain_cnt_next;
      ret_drain_reg  <= ret_drain_next;
      // Fetch stays stopped while a drain-time access is being stretched.
      fetch_stop_reg <= (state_next == S_DRAIN) || (state_next == S_HALTED) ||
                        ((state_next == S_MEM_WAIT) && ret_drain_next);
      halted_reg     <= (state_next == S_HALTED);
      if ((freeze_next || ld_inst_halt_next) && (state_reg != S_HALTED) &&
          (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign freeze       = freeze_next;
  assign ld_inst_halt = ld_inst_halt_next;
  assign fetch_stop   = fetch_stop_reg;
  assign halted       = halted_reg;
  assign stall_cnt    = stall_cnt_reg;

endmodule
